// File: rtl/block_ram_param_if.sv
// rtl/block_ram_param_if.sv - access and status bundle for block_ram_param
interface block_ram_param_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 13
);
    logic              ena;
    logic              wea;
    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] dina;
    logic              clr_req;
    logic [DATA_W-1:0] douta;
    logic              rd_valid;
    logic              busy;

    modport master (
        output ena, wea, addra, dina, clr_req,
        input  douta, rd_valid, busy
    );

    modport slave (
        input  ena, wea, addra, dina, clr_req,
        output douta, rd_valid, busy
    );
endinterface

// File: rtl/block_ram_param.sv
// rtl/block_ram_param.sv - single-port read-first RAM with clear sequencer
module block_ram_param #(
    parameter int                DATA_W  = 8,
    parameter int                ADDR_W  = 13,
    parameter int                RD_LAT  = 1,
    parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    block_ram_param_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] clr_cnt_q;
    logic              busy_q;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] douta_q;
    logic              rd_valid_q;

    logic              acc;
    logic              acc_rd;
    logic              clr_we;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [DATA_W-1:0] mem_wd;

    // User access is only taken while idle; reset blocks everything.
    assign acc    = bus.ena && !busy_q && !reset;
    assign acc_rd = acc && !bus.wea;
    assign clr_we = (state_q == CLEAR) && !reset;

    // Single write port shared between the clear sequencer and user writes
    always_comb begin
        mem_we = 1'b0;
        mem_wa = bus.addra;
        mem_wd = bus.dina;
        if (clr_we) begin
            mem_we = 1'b1;
            mem_wa = clr_cnt_q;
            mem_wd = CLR_VAL;
        end else if (acc && bus.wea) begin
            mem_we = 1'b1;
        end
    end

    // Array storage, no reset so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_wa] <= mem_wd;
        end
    end

    // Clear controller: walks every address once, then returns to idle
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
            busy_q    <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.clr_req) begin
                        state_q   <= CLEAR;
                        clr_cnt_q <= '0;
                        busy_q    <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (clr_cnt_q == {ADDR_W{1'b1}}) begin
                        state_q   <= IDLE;
                        clr_cnt_q <= '0;
                        busy_q    <= 1'b0;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q   <= CLEAR;
                    clr_cnt_q <= '0;
                    busy_q    <= 1'b1;
                end
            endcase
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [DATA_W-1:0] rd_data_q;
            logic              acc_q;
            logic              rd_q;

            // Two-stage read: array register, then output register
            always_ff @(posedge clk) begin
                if (acc) begin
                    rd_data_q <= mem_q[bus.addra];
                end
                if (reset) begin
                    acc_q      <= 1'b0;
                    rd_q       <= 1'b0;
                    douta_q    <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    acc_q      <= acc;
                    rd_q       <= acc_rd;
                    rd_valid_q <= rd_q;
                    if (acc_q) begin
                        douta_q <= rd_data_q;
                    end
                end
            end
        end else begin : g_lat1
            // Single-stage read: pre-write contents land on douta directly
            always_ff @(posedge clk) begin
                if (reset) begin
                    douta_q    <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= acc_rd;
                    if (acc) begin
                        douta_q <= mem_q[bus.addra];
                    end
                end
            end
        end
    endgenerate

    assign bus.douta    = douta_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_block_ram_param.sv
// tb/tb_block_ram_param.sv - scoreboard bench for block_ram_param
module tb_block_ram_param;
    localparam int DW = 8;
    localparam int AW = 13;
    localparam int DEPTH = 1 << AW;

    typedef struct {
        int          due;
        logic [7:0]  data;
        bit          is_rd;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_r = 1'b0;
    logic          ena_r = 1'b0;
    logic          wea_r = 1'b0;
    logic [AW-1:0] addr_r = '0;
    logic [DW-1:0] din_r = '0;
    logic          clr_r = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    logic [7:0] mem_a [DEPTH];
    logic [7:0] mem_b [DEPTH];
    exp_t       q_a[$];
    exp_t       q_b[$];
    bit         m_busy = 1'b0;
    int         m_cnt = 0;
    logic [7:0] ea_d = '0;
    logic [7:0] eb_d = '0;
    bit         ea_v = 1'b0;
    bit         eb_v = 1'b0;

    block_ram_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus_a ();
    block_ram_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus_b ();

    assign bus_a.ena = ena_r;   assign bus_b.ena = ena_r;
    assign bus_a.wea = wea_r;   assign bus_b.wea = wea_r;
    assign bus_a.addra = addr_r; assign bus_b.addra = addr_r;
    assign bus_a.dina = din_r;  assign bus_b.dina = din_r;
    assign bus_a.clr_req = clr_r; assign bus_b.clr_req = clr_r;

    block_ram_param #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1), .CLR_VAL(8'h00)) u_dut_a (
        .clk(clk), .reset(reset_r), .bus(bus_a)
    );
    block_ram_param #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(2), .CLR_VAL(8'hA5)) u_dut_b (
        .clk(clk), .reset(reset_r), .bus(bus_b)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // One clock: update the model from the driven inputs, advance, compare.
    task automatic step();
        bit   rst_now;
        exp_t e;
        rst_now = reset_r;
        if (rst_now) begin
            q_a.delete();
            q_b.delete();
            m_busy = 1'b1;
            m_cnt  = 0;
        end else begin
            if (ena_r && !m_busy) begin
                e.is_rd = !wea_r;
                e.due = cyc + 1; e.data = mem_a[addr_r]; q_a.push_back(e);
                e.due = cyc + 2; e.data = mem_b[addr_r]; q_b.push_back(e);
                if (wea_r) begin
                    mem_a[addr_r] = din_r;
                    mem_b[addr_r] = din_r;
                end
            end
            if (m_busy) begin
                mem_a[m_cnt] = 8'h00;
                mem_b[m_cnt] = 8'hA5;
                if (m_cnt == DEPTH - 1) m_busy = 1'b0;
                m_cnt++;
            end else if (clr_r) begin
                m_busy = 1'b1;
                m_cnt  = 0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rst_now) begin
            ea_d = '0; ea_v = 1'b0;
            eb_d = '0; eb_v = 1'b0;
        end else begin
            ea_v = 1'b0;
            if (q_a.size() > 0 && q_a[0].due == cyc) begin
                e = q_a.pop_front(); ea_d = e.data; ea_v = e.is_rd;
            end
            eb_v = 1'b0;
            if (q_b.size() > 0 && q_b[0].due == cyc) begin
                e = q_b.pop_front(); eb_d = e.data; eb_v = e.is_rd;
            end
        end
        chk("a_douta",    64'(bus_a.douta),    64'(ea_d));
        chk("a_rd_valid", 64'(bus_a.rd_valid), 64'(ea_v));
        chk("a_busy",     64'(bus_a.busy),     64'(m_busy));
        chk("b_douta",    64'(bus_b.douta),    64'(eb_d));
        chk("b_rd_valid", 64'(bus_b.rd_valid), 64'(eb_v));
        chk("b_busy",     64'(bus_b.busy),     64'(m_busy));
    endtask

    task automatic drive(input bit e, input bit w, input int a, input int d, input bit c);
        ena_r  = e;
        wea_r  = w;
        addr_r = AW'(a);
        din_r  = DW'(d);
        clr_r  = c;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    // Runs while the DUT reports busy, with random ignored traffic; returns length.
    task automatic ride_clear(input int pulse_at, output int len);
        len = 0;
        while (bus_a.busy === 1'b1 && len < DEPTH + 100) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 255)),
                  (len == pulse_at));
            len++;
        end
        clr_r = 1'b0;
    endtask

    initial begin
        int len;
        for (int i = 0; i < DEPTH; i++) begin
            mem_a[i] = 8'h00;
            mem_b[i] = 8'h00;
        end

        reset_r = 1'b1;
        step();
        reset_r = 1'b0;
        ride_clear(-1, len);
        chk("clr_len_reset", 64'(len), 64'(DEPTH));
        idle(2);
        drive(1'b1, 1'b0, DEPTH - 1, 0, 1'b0);
        idle(3);

        drive(1'b1, 1'b1, 0, 100, 1'b0);
        drive(1'b1, 1'b1, 1, 130, 1'b0);
        drive(1'b1, 1'b1, 2, 200, 1'b0);
        drive(1'b1, 1'b0, 2, 0, 1'b0);
        drive(1'b1, 1'b0, 1, 0, 1'b0);
        drive(1'b1, 1'b0, 0, 0, 1'b0);
        idle(3);

        drive(1'b1, 1'b1, 5, 55, 1'b0);
        drive(1'b1, 1'b1, 5, 77, 1'b0);
        drive(1'b1, 1'b0, 5, 0, 1'b0);
        idle(3);

        drive(1'b1, 1'b0, 0, 0, 1'b1);
        ride_clear(100, len);
        chk("clr_len_req", 64'(len), 64'(DEPTH));
        idle(1);
        drive(1'b1, 1'b0, 0, 0, 1'b0);
        idle(3);

        drive(1'b1, 1'b1, 3, 8'h3C, 1'b0);
        drive(1'b0, 1'b0, 0, 0, 1'b1);
        idle(4000);
        reset_r = 1'b1;
        drive(1'b1, 1'b1, 3, 8'h99, 1'b0);
        reset_r = 1'b0;
        ride_clear(50, len);
        chk("clr_len_midrst", 64'(len), 64'(DEPTH));
        idle(1);
        drive(1'b1, 1'b0, 3, 0, 1'b0);
        idle(3);

        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 255)), 1'b0);
        end
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
